// File: rtl/fetch_queue.sv
// Prefetch queue ahead of IF/ID. It fetches sequential words over req/ack and buffers up to DEPTH {pc+4, instr} pairs.
// Defining FETCH_QUEUE_BYPASS_EN forwards an ack straight to the outputs when the queue is empty (zero-cycle ack-to-out).
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc4,
    output logic [31:0] out_instr
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   addr_q, addr_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc4_mem   [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic        q_valid;
    logic        ack_take;
    logic        bypass;
    logic        push;
    logic        pop;
    logic [31:0] fpc_inc;
    logic        unused_pc_lsb;

    // Redirect targets are word aligned; the two low bits carry no information.
    assign unused_pc_lsb = ^redirect_pc[1:0];

    assign q_valid  = (count_q != '0);
    assign fpc_inc  = fpc_q + 32'd4;
    assign ack_take = (state_q == WAIT) && mem_ack && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = ack_take && !q_valid;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word consumed by decode this cycle never occupies a slot.
    assign push = ack_take && !(bypass && !hold);
    assign pop  = q_valid && !hold && !redirect;

    assign mem_req   = (state_q != IDLE);
    assign mem_addr  = addr_q;
    assign out_valid = q_valid || bypass;

    always_comb begin
        out_pc4   = 32'd0;
        out_instr = 32'd0;
        if (bypass) begin
            out_pc4   = fpc_inc;
            out_instr = mem_rdata;
        end else if (q_valid) begin
            out_pc4   = pc4_mem[head_q];
            out_instr = instr_mem[head_q];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop)  head_d = head_q + AW'(1);
            if (push) tail_d = tail_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (!redirect && (count_q < DEPTH_C)) begin
                    state_d = WAIT;
                    addr_d  = fpc_q;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    if (redirect) begin
                        state_d = IDLE;
                    end else begin
                        fpc_d = fpc_inc;
                        if (count_d < DEPTH_C) begin
                            state_d = WAIT;
                            addr_d  = fpc_inc;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (redirect) fpc_d = {redirect_pc[31:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fpc_q   <= RESET_PC;
            addr_q  <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            addr_q  <= addr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc4_mem[tail_q]   <= fpc_inc;
            instr_mem[tail_q] <= mem_rdata;
        end
    end
endmodule
